// File: rtl/muldiv_scheduler.sv
// muldiv_scheduler: sequences the shared multi-cycle multiply/divide unit.
// A mul/div seen in DX freezes the front end, the unit is launched and
// awaited (with a timeout), the result or exception code is written through
// an override write port once MW is not writing, and the instruction then
// leaves DX as a bubble.
//
// Handshake: md_ctrl_mult/md_ctrl_div are single-cycle start pulses issued
// in ISSUE; md_ready is a single-cycle valid from the unit, honoured only in
// BUSY (md_exception and md_result are sampled with it). The override write
// port is valid only when wb_enable=1, which happens in WRITE with
// MW_write_enable=0; the pipeline's own writeback always has priority.
module muldiv_scheduler #(
    parameter int MAX_CYCLES = 40,
    localparam int CW = $clog2(MAX_CYCLES + 1)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] DX_instruction,
    input  logic [31:0] DX_operand_a,
    input  logic [31:0] DX_operand_b,
    input  logic        MW_write_enable,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    output logic        stall,
    output logic        dx_bubble,
    output logic        wb_enable,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_BUSY  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          op_div_q;
    logic [4:0]    rd_q;
    logic [31:0]   result_q;
    logic          exc_q;

    logic [4:0]    opcode;
    logic [4:0]    alu_op;
    logic          is_mul;
    logic          is_div;
    logic          detect;
    logic          frozen;
    logic          write_slot;
    logic          unused_dx_bits;

    // Decode the DX instruction; only opcode and ALU op fields matter here.
    always_comb begin
        opcode = DX_instruction[31:27];
        alu_op = DX_instruction[6:2];
        is_mul = (opcode == 5'b00000) && (alu_op == 5'b00110);
        is_div = (opcode == 5'b00000) && (alu_op == 5'b00111);
    end

    assign unused_dx_bits = ^{DX_instruction[21:7], DX_instruction[1:0]};

    // Pipeline control: detection acts in the same cycle, so stall/bubble
    // are combinational; detection is gated by reset so outputs read 0
    // while reset is held even if DX still carries a mul/div.
    always_comb begin
        detect     = reset && (state_q == S_IDLE) && (is_mul || is_div);
        frozen     = (state_q == S_ISSUE) || (state_q == S_BUSY) || (state_q == S_WRITE);
        stall      = detect || frozen;
        dx_bubble  = stall || (state_q == S_DONE);
        write_slot = (state_q == S_WRITE) && !MW_write_enable;
    end

    // Override write port: rd=0 without exception suppresses the write, an
    // exception redirects it to r30 with code 4 (mul) or 5 (div).
    always_comb begin
        wb_enable = write_slot && (exc_q || (rd_q != 5'd0));
        wb_reg    = 5'd0;
        wb_data   = 32'd0;
        if (wb_enable) begin
            if (exc_q) begin
                wb_reg  = 5'd30;
                wb_data = op_div_q ? 32'd5 : 32'd4;
            end else begin
                wb_reg  = rd_q;
                wb_data = result_q;
            end
        end
    end

    assign dbg_state = state_q;

    // Scheduler FSM with its latched operands, result and start pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_div_q     <= 1'b0;
            rd_q         <= 5'd0;
            result_q     <= 32'd0;
            exc_q        <= 1'b0;
            md_operand_a <= 32'd0;
            md_operand_b <= 32'd0;
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mul || is_div) begin
                        md_operand_a <= DX_operand_a;
                        md_operand_b <= DX_operand_b;
                        rd_q         <= DX_instruction[26:22];
                        op_div_q     <= is_div;
                        exc_q        <= 1'b0;
                        md_ctrl_mult <= is_mul;
                        md_ctrl_div  <= is_div;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    md_ctrl_mult <= 1'b0;
                    md_ctrl_div  <= 1'b0;
                    cnt_q        <= '0;
                    state_q      <= S_BUSY;
                end
                S_BUSY: begin
                    // md_ready takes priority over a timeout in the same cycle.
                    if (md_ready) begin
                        result_q <= md_result;
                        exc_q    <= md_exception;
                        state_q  <= S_WRITE;
                    end else if (cnt_q == CW'(MAX_CYCLES)) begin
                        result_q <= 32'd0;
                        exc_q    <= 1'b1;
                        state_q  <= S_WRITE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WRITE: begin
                    if (!MW_write_enable) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Bench for muldiv_scheduler: directed mul/div scenarios; expected override
// writes (cycle, register, data) are queued at detection time and a monitor
// compares every write the DUT presents.
module tb_muldiv_scheduler;

    localparam int MAX_CYCLES = 40;
    localparam int W = 53;   // {cycle[15:0], reg[4:0], data[31:0]}

    logic        clock;
    logic        reset;
    logic [31:0] DX_instruction;
    logic [31:0] DX_operand_a;
    logic [31:0] DX_operand_b;
    logic        MW_write_enable;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_operand_a;
    logic [31:0] md_operand_b;
    logic        stall;
    logic        dx_bubble;
    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [2:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    muldiv_scheduler #(.MAX_CYCLES(MAX_CYCLES)) dut (
        .clock          (clock),
        .reset          (reset),
        .DX_instruction (DX_instruction),
        .DX_operand_a   (DX_operand_a),
        .DX_operand_b   (DX_operand_b),
        .MW_write_enable(MW_write_enable),
        .md_ready       (md_ready),
        .md_exception   (md_exception),
        .md_result      (md_result),
        .md_ctrl_mult   (md_ctrl_mult),
        .md_ctrl_div    (md_ctrl_div),
        .md_operand_a   (md_operand_a),
        .md_operand_b   (md_operand_b),
        .stall          (stall),
        .dx_bubble      (dx_bubble),
        .wb_enable      (wb_enable),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .dbg_state      (dbg_state)
    );

    // Clock and cycle counter.
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] md_instr(input bit div, input logic [4:0] rd);
        return {5'b00000, rd, 15'd0, (div ? 5'b00111 : 5'b00110), 2'b00};
    endfunction

    // Monitor: every override write must match the head of the expected queue.
    always @(negedge clock) begin
        logic [W-1:0] e;
        if (reset && wb_enable) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_write: got r%0d=%0h expected no write (cycle %0d)",
                         wb_reg, wb_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("wb_cycle", 32'(cyc[15:0]), 32'(e[52:37]));
                check("wb_reg", 32'(wb_reg), 32'(e[36:32]));
                check("wb_data", wb_data, e[31:0]);
            end
        end
    end

    // One mul/div from detection to the IDLE cycle after DONE.
    // n < 0: md_ready never comes (timeout). Otherwise md_ready is raised
    // when the BUSY counter reads n, giving a write 3+n cycles after
    // detection, plus `collide` cycles of MW_write_enable.
    task automatic run_op(input bit div, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input int n, input bit exc,
                          input logic [31:0] res, input int collide);
        int d;
        int wcyc;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        bit expect_write;
        DX_instruction = md_instr(div, rd);
        DX_operand_a   = a;
        DX_operand_b   = b;
        #1;
        d = cyc;
        check("detect_stall", 32'(stall), 32'd1);
        check("detect_bubble", 32'(dx_bubble), 32'd1);
        check("detect_no_pulse", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
        wcyc = d + 3 + ((n < 0) ? MAX_CYCLES : n) + collide;
        if (exc || n < 0) begin
            exp_reg = 5'd30;
            exp_data = div ? 32'd5 : 32'd4;
            expect_write = 1'b1;
        end else begin
            exp_reg = rd;
            exp_data = res;
            expect_write = (rd != 5'd0);
        end
        if (expect_write) exp_q.push_back({wcyc[15:0], exp_reg, exp_data});

        step();  // ISSUE
        check("issue_pulse", 32'({md_ctrl_mult, md_ctrl_div}), div ? 32'd1 : 32'd2);
        check("issue_operand_a", md_operand_a, a);
        check("issue_operand_b", md_operand_b, b);
        DX_operand_a = ~a;
        DX_operand_b = ~b;

        step();  // first BUSY cycle
        check("busy_pulse_gone", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
        check("busy_stall", 32'(stall), 32'd1);
        if (n < 0) begin
            repeat (MAX_CYCLES + 1) step();
        end else begin
            repeat (n) step();
            md_ready = 1'b1;
            md_exception = exc;
            md_result = res;
            step();
            md_ready = 1'b0;
            md_exception = 1'b0;
            md_result = 32'd0;
        end

        // WRITE, possibly held off by the pipeline's own writeback.
        check("write_operand_a", md_operand_a, a);
        repeat (collide) begin
            MW_write_enable = 1'b1;
            #1;
            check("collide_stall", 32'(stall), 32'd1);
            check("collide_no_write", 32'(wb_enable), 32'd0);
            step();
        end
        MW_write_enable = 1'b0;
        #1;
        check("write_stall", 32'(stall), 32'd1);
        check("write_enable", 32'(wb_enable), 32'(expect_write));

        step();  // DONE, DX still holds the mul/div
        check("done_stall", 32'(stall), 32'd0);
        check("done_bubble", 32'(dx_bubble), 32'd1);
        check("done_state", 32'(dbg_state), 32'd4);

        step();  // IDLE
        DX_instruction = 32'd0;
        #1;
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_bubble", 32'(dx_bubble), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 32'({stall, dx_bubble, md_ctrl_mult, md_ctrl_div, wb_enable}), 32'd0);
        check({name, "_opa"}, md_operand_a, 32'd0);
        check({name, "_opb"}, md_operand_b, 32'd0);
        check({name, "_wbreg"}, 32'(wb_reg), 32'd0);
        check({name, "_wbdata"}, wb_data, 32'd0);
        check({name, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        DX_instruction = 32'd0;
        DX_operand_a = 32'd0;
        DX_operand_b = 32'd0;
        MW_write_enable = 1'b0;
        md_ready = 1'b0;
        md_exception = 1'b0;
        md_result = 32'd0;
        step();
        step();
        check_all_zero("reset_state");
        reset = 1'b1;
        step();

        // mul r5 = 6*7, ready when counter reads 16: write 19 cycles after detection.
        run_op(1'b0, 5'd5, 32'd6, 32'd7, 16, 1'b0, 32'd42, 0);
        // div r3 by zero: exception, r30 = 5, r3 untouched.
        run_op(1'b1, 5'd3, 32'd10, 32'd0, 5, 1'b1, 32'hdeadbeef, 0);
        // mul r7 = 3*4 colliding with two pipeline writebacks.
        run_op(1'b0, 5'd7, 32'd3, 32'd4, 2, 1'b0, 32'd12, 2);
        // mul r8 with no md_ready: timeout, r30 = 4.
        run_op(1'b0, 5'd8, 32'd2, 32'd2, -1, 1'b0, 32'd0, 0);
        // A late md_ready afterwards is ignored.
        md_ready = 1'b1;
        md_result = 32'd123;
        step();
        step();
        md_ready = 1'b0;
        md_result = 32'd0;
        check("late_ready_idle", 32'(stall), 32'd0);
        // md_ready in the same cycle the counter hits MAX_CYCLES wins.
        run_op(1'b0, 5'd11, 32'h1000, 32'h2, MAX_CYCLES, 1'b0, 32'h2000, 0);
        // mul r0: no write, FSM still passes DONE; back-to-back div follows.
        run_op(1'b0, 5'd0, 32'd9, 32'd11, 1, 1'b0, 32'd99, 0);
        run_op(1'b1, 5'd12, 32'd100, 32'd7, 0, 1'b0, 32'd14, 0);

        // Reset during BUSY aborts the operation with no writeback.
        DX_instruction = md_instr(1'b0, 5'd9);
        DX_operand_a = 32'd5;
        DX_operand_b = 32'd5;
        step();
        step();
        step();
        step();
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        md_ready = 1'b1;
        md_result = 32'd77;
        step();
        step();
        md_ready = 1'b0;
        md_result = 32'd0;
        reset = 1'b1;
        // The mul still in DX is picked up again and completes normally.
        run_op(1'b0, 5'd9, 32'd5, 32'd5, 3, 1'b0, 32'd25, 0);

        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
